// File: rtl/debug_poke.sv
// debug_poke: turns push-button presses plus the slide switches into
// register-write transactions for the datapath debug port.
// Entry takes two presses: the first picks a register index, the second
// supplies the data byte. Each completed entry issues one valid/ready write.
//
// Ports:
//   clk      - system clock, all state on the rising edge
//   rst      - asynchronous active-low reset
//   key_n    - raw push-button, asynchronous, 0 = pressed
//   sw       - raw switches: [2:0] index, [7:0] data, [9] cancel
//   wr_valid - write request pending (high in SEND)
//   wr_ready - datapath accepts when wr_valid & wr_ready at an edge
//   wr_sel   - register index (A,B,C,D,E,F,H,L)
//   wr_data  - byte to write
//   phase    - entry step: 0 ADDR, 1 DATA, 2 SEND
module debug_poke #(
  parameter int unsigned DB_CYCLES = 250000,
  parameter int unsigned CNT_W     = $clog2(DB_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic [9:0] sw,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [2:0] wr_sel,
  output logic [7:0] wr_data,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    ADDR = 2'd0,
    DATA = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             key_s1;
  logic             key_s2;
  logic             key_db;
  logic [CNT_W-1:0] db_cnt;
  logic             press;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] sel_nxt;
  logic [7:0] data_nxt;

  // Two-flop synchroniser; idles at released (1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  // Counter measures how long the synced key has disagreed with the
  // accepted level; it clears at the terminal count so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_db <= 1'b1;
      db_cnt <= '0;
    end else if (key_s2 == key_db) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      key_db <= key_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // Press fires in the cycle whose edge moves the debounced level 1->0,
  // so the FSM reacts on the same edge the level is accepted.
  always_comb begin
    press = key_db & ~key_s2 & (db_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ADDR;
      wr_sel  <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_nxt;
      wr_sel  <= sel_nxt;
      wr_data <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = wr_sel;
    data_nxt  = wr_data;
    case (state)
      ADDR: begin
        if (press) begin
          sel_nxt   = sw[2:0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (press) begin
          if (sw[9]) begin
            state_nxt = ADDR;
          end else begin
            data_nxt  = sw[7:0];
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        // Presses here are dropped, not queued.
        if (wr_ready) state_nxt = ADDR;
      end
      default: state_nxt = ADDR;
    endcase
  end

  always_comb begin
    wr_valid = (state == SEND);
    phase    = state;
  end

endmodule

// File: tb/tb_debug_poke.sv
module tb_debug_poke;

  localparam int unsigned DB = 4;

  logic       clk;
  logic       rst;
  logic       key_n;
  logic [9:0] sw;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_sel;
  logic [7:0] wr_data;
  logic [1:0] phase;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned hs_dut;
  int unsigned hs_exp;

  debug_poke #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst     (rst),
    .key_n   (key_n),
    .sw      (sw),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .phase   (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted transfers as seen on the interface.
  always @(posedge clk) begin
    if (rst && wr_valid && wr_ready) hs_dut++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: key is seen two samples late; the accepted level flips
  // once the last DB seen samples all disagree with it.
  logic     m_dly [2];
  logic     m_win [DB];
  logic     m_lvl;
  int       m_st;
  int       m_sel;
  int       m_data;

  task automatic model_reset();
    m_dly[0] = 1'b1;
    m_dly[1] = 1'b1;
    for (int i = 0; i < int'(DB); i++) m_win[i] = 1'b1;
    m_lvl  = 1'b1;
    m_st   = 0;
    m_sel  = 0;
    m_data = 0;
  endtask

  task automatic model_edge();
    logic seen;
    logic flip;
    logic prs;
    if (!rst) begin
      model_reset();
      return;
    end
    seen = m_dly[1];
    for (int i = int'(DB) - 1; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = seen;
    m_dly[1] = m_dly[0];
    m_dly[0] = key_n;
    flip = 1'b1;
    for (int i = 0; i < int'(DB); i++) if (m_win[i] == m_lvl) flip = 1'b0;
    prs = 1'b0;
    if (flip) begin
      m_lvl = ~m_lvl;
      for (int i = 0; i < int'(DB); i++) m_win[i] = m_lvl;
      prs = (m_lvl == 1'b0);
    end
    if (m_st == 2) begin
      if (wr_ready) begin
        m_st = 0;
        hs_exp++;
      end
    end else if (m_st == 0) begin
      if (prs) begin
        m_sel = int'(sw[2:0]);
        m_st  = 1;
      end
    end else begin
      if (prs) begin
        if (sw[9]) m_st = 0;
        else begin
          m_data = int'(sw[7:0]);
          m_st   = 2;
        end
      end
    end
  endtask

  task automatic compare_model();
    check("phase", 32'(phase), 32'(m_st));
    check("wr_valid", 32'(wr_valid), 32'(m_st == 2));
    check("wr_sel", 32'(wr_sel), 32'(m_sel));
    check("wr_data", 32'(wr_data), 32'(m_data));
  endtask

  // One clock: model follows the edge, DUT sampled 1 ns later, inputs
  // are changed by callers after the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [9:0] s, input int low, input int high);
    sw    = s;
    key_n = 1'b0;
    ticks(low);
    key_n = 1'b1;
    ticks(high);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    hs_dut   = 0;
    hs_exp   = 0;
    rst      = 1'b0;
    key_n    = 1'b1;
    sw       = '0;
    wr_ready = 1'b0;
    model_reset();
    #1;
    check("rst_phase", 32'(phase), 0);
    check("rst_valid", 32'(wr_valid), 0);
    check("rst_sel", 32'(wr_sel), 0);
    check("rst_data", 32'(wr_data), 0);
    @(negedge clk);

    // Inputs wiggle while held in reset.
    for (int i = 0; i < 12; i++) begin
      key_n    = 1'(i % 2);
      sw       = 10'($urandom);
      wr_ready = 1'($urandom);
      tick();
    end
    key_n = 1'b1;
    wr_ready = 1'b0;
    rst = 1'b1;
    ticks(3);

    // Basic write.
    push(10'h003, 10, 10);
    check("basic_phase1", 32'(phase), 1);
    check("basic_sel", 32'(wr_sel), 3);
    sw = 10'h0A5;
    key_n = 1'b0;
    ticks(10);
    check("basic_phase2", 32'(phase), 2);
    check("basic_valid", 32'(wr_valid), 1);
    check("basic_data", 32'(wr_data), 32'h0A5);
    key_n = 1'b1;
    ticks(5);
    check("basic_hold", 32'(wr_valid), 1);
    check("basic_no_hs", hs_dut, 0);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    check("basic_done_phase", 32'(phase), 0);
    check("basic_done_valid", 32'(wr_valid), 0);
    check("basic_one_hs", hs_dut, 1);
    ticks(10);

    // Glitch rejection, then a long hold gives exactly one press.
    push(10'h007, 3, 10);
    check("glitch_phase", 32'(phase), 0);
    push(10'h007, 20, 10);
    check("hold_phase", 32'(phase), 1);
    check("hold_sel", 32'(wr_sel), 7);

    // Cancel.
    push(10'h2FF, 10, 10);
    check("cancel_phase", 32'(phase), 0);
    check("cancel_data", 32'(wr_data), 32'h0A5);
    check("cancel_sel", 32'(wr_sel), 7);
    check("cancel_no_hs", hs_dut, 1);

    // Presses in SEND are ignored.
    push(10'h003, 10, 10);
    push(10'h0A5, 10, 10);
    check("send_phase", 32'(phase), 2);
    push(10'h011, 10, 10);
    check("send_ign_data", 32'(wr_data), 32'h0A5);
    check("send_ign_phase", 32'(phase), 2);
    wr_ready = 1'b1;
    ticks(15);
    wr_ready = 1'b0;
    check("send_ret_phase", 32'(phase), 0);
    check("send_one_hs", hs_dut, 2);

    // Reset mid-SEND drops wr_valid before the next edge.
    push(10'h001, 10, 10);
    push(10'h05A, 10, 10);
    check("mid_pre_valid", 32'(wr_valid), 1);
    wr_ready = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("mid_async_valid", 32'(wr_valid), 0);
    check("mid_async_phase", 32'(phase), 0);
    @(negedge clk);
    ticks(2);
    rst = 1'b1;
    wr_ready = 1'b0;
    ticks(2);
    check("mid_phase", 32'(phase), 0);
    check("mid_no_hs", hs_dut, 2);

    // Randomised presses, glitches, cancels and ready patterns.
    for (int i = 0; i < 250; i++) begin
      logic [9:0] s;
      s = 10'($urandom);
      if ($urandom_range(3, 0) != 0) s[9] = 1'b0;
      sw = s;
      key_n = 1'b0;
      for (int j = 0; j < int'($urandom_range(12, 1)); j++) begin
        wr_ready = ($urandom_range(3, 0) == 0);
        tick();
      end
      key_n = 1'b1;
      for (int j = 0; j < int'($urandom_range(12, 1)); j++) begin
        wr_ready = ($urandom_range(3, 0) == 0);
        tick();
      end
    end
    wr_ready = 1'b0;
    check("hs_count", hs_dut, hs_exp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
